// File: rtl/dma_regs_pkg.sv
// dma_regs_pkg: shared definitions for the DMA channel register bank.
//   Channel word offsets, per-channel FSM encoding, STATUS/CTRL bit positions,
//   the unmapped-read pattern and byte-strobe helpers.
package dma_regs_pkg;

  // Word offsets inside one 8-word channel window
  localparam logic [2:0] OffAddr     = 3'd0;
  localparam logic [2:0] OffLbaLo    = 3'd1;
  localparam logic [2:0] OffLbaHi    = 3'd2;
  localparam logic [2:0] OffCount    = 3'd3;
  localparam logic [2:0] OffType     = 3'd4;
  localparam logic [2:0] OffCtrl     = 3'd5;
  localparam logic [2:0] OffStatus   = 3'd6;
  localparam logic [2:0] OffLastAddr = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StBusy = 2'd2
  } chan_state_e;

  // STATUS layout: [1:0] state, sticky bits, [31:16] completion count
  localparam int unsigned StatDone   = 2;
  localparam int unsigned StatErr    = 3;
  localparam int unsigned StatCmdErr = 4;

  // CTRL command bits
  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlAbort = 1;
  localparam int unsigned CtrlClear = 2;

  localparam logic [31:0] DefaultRdata = 32'hd34db33f;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  // Bytes with a cleared strobe keep their old value
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/dma_chan_ctrl.sv
// dma_chan_ctrl: one DMA channel's configuration registers, start/ack/done FSM,
// sticky status bits and 16-bit completion counter.
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   wr_en/wr_off           write to this channel's window at word offset wr_off
//   wr_data/wr_mask        raw write data and expanded byte-strobe mask
//   rd_off/rd_data         combinational register read at word offset rd_off
//   mem_address, lba,
//   sector_cnt, dma_type   command fields towards the engine
//   dma_req/dma_ack        request level (held in PEND) and engine accept
//   dma_done/dma_err       completion pulse and its error qualifier
//   done_evt               completion accepted this cycle (feeds IRQ pending)
module dma_chan_ctrl
  import dma_regs_pkg::*;
#(
  parameter int unsigned DMA_ALIGN = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             wr_en,
  input  logic [2:0]       wr_off,
  input  logic [31:0]      wr_data,
  input  logic [31:0]      wr_mask,
  input  logic [2:0]       rd_off,
  output logic [31:0]      rd_data,
  output logic [31:0]      mem_address,
  output logic [47:0]      lba,
  output logic [CNT_W-1:0] sector_cnt,
  output logic             dma_type,
  output logic             dma_req,
  input  logic             dma_ack,
  input  logic             dma_done,
  input  logic             dma_err,
  output logic             done_evt
);

  localparam logic [31:0] AlignMask = ~((32'd1 << DMA_ALIGN) - 32'd1);

  chan_state_e state_q, state_d;

  logic [31:0]      addr_q;
  logic [31:0]      lba_lo_q;
  logic [15:0]      lba_hi_q;
  logic [CNT_W-1:0] count_q;
  logic             type_q;
  logic [31:0]      last_addr_q;
  logic [15:0]      cmpl_cnt_q;
  logic             done_q, err_q, cmd_err_q;

  logic ctrl_wr, cfg_wr, start, abort, clr, in_idle, cmd_err_set;
  logic [31:0] status;

  assign in_idle = (state_q == StIdle);
  assign ctrl_wr = wr_en && (wr_off == OffCtrl);
  assign cfg_wr  = wr_en && (wr_off <= OffType);
  assign start   = ctrl_wr && wr_data[CtrlStart] && wr_mask[CtrlStart];
  assign abort   = ctrl_wr && wr_data[CtrlAbort] && wr_mask[CtrlAbort];
  assign clr     = ctrl_wr && wr_data[CtrlClear] && wr_mask[CtrlClear];

  // Config writes and restarts are only legal while idle
  assign cmd_err_set = !in_idle && (cfg_wr || start);

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StPend;
      // An ack in the same cycle as abort wins: the engine has already taken the command
      StPend: begin
        if (dma_ack) begin
          state_d = StBusy;
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      StBusy: if (dma_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    dma_req  = (state_q == StPend);
    done_evt = (state_q == StBusy) && dma_done;
  end

  // Config registers, sticky status and counter
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr_q      <= '0;
      lba_lo_q    <= '0;
      lba_hi_q    <= '0;
      count_q     <= '0;
      type_q      <= 1'b0;
      last_addr_q <= '0;
      cmpl_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      if (cfg_wr && in_idle) begin
        unique case (wr_off)
          OffAddr:  addr_q   <= byte_merge(addr_q, wr_data, wr_mask);
          OffLbaLo: lba_lo_q <= byte_merge(lba_lo_q, wr_data, wr_mask);
          OffLbaHi: lba_hi_q <= 16'(byte_merge({16'h0, lba_hi_q}, wr_data, wr_mask));
          OffCount: count_q  <= CNT_W'(byte_merge(32'(count_q), wr_data, wr_mask));
          OffType:  type_q   <= 1'(byte_merge({31'h0, type_q}, wr_data, wr_mask));
          default: ;
        endcase
      end
      // Clear first so that a same-cycle set overrides it
      if (clr) begin
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        cmd_err_q <= 1'b0;
      end
      if (done_evt) begin
        done_q      <= 1'b1;
        err_q       <= dma_err;
        last_addr_q <= addr_q;
        cmpl_cnt_q  <= cmpl_cnt_q + 16'd1;
      end
      if (cmd_err_set) begin
        cmd_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    status             = '0;
    status[1:0]        = state_q;
    status[StatDone]   = done_q;
    status[StatErr]    = err_q;
    status[StatCmdErr] = cmd_err_q;
    status[31:16]      = cmpl_cnt_q;
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_off)
      OffAddr:     rd_data = addr_q;
      OffLbaLo:    rd_data = lba_lo_q;
      OffLbaHi:    rd_data = {16'h0, lba_hi_q};
      OffCount:    rd_data = 32'(count_q);
      OffType:     rd_data = {31'h0, type_q};
      OffCtrl:     rd_data = '0;
      OffStatus:   rd_data = status;
      OffLastAddr: rd_data = last_addr_q;
      default:     rd_data = '0;
    endcase
  end

  assign mem_address = addr_q & AlignMask;
  assign lba         = {lba_hi_q, lba_lo_q};
  assign sector_cnt  = count_q;
  assign dma_type    = type_q;

endmodule

// File: rtl/dma_chan_regs.sv
// dma_chan_regs: multi-channel DMA command register bank on the BRAM-style slave port.
//   Decodes word addresses [7:0], builds the byte-strobe mask, instantiates one
//   dma_chan_ctrl per channel, muxes the registered read data and drives irq.
// Ports:
//   ACLK, ARESETN               clock, synchronous active-low reset
//   bram_waddr/wdata/wstb/wen   write port (byte-merged writes)
//   bram_raddr/ren/regen/rdata  read port: ren latches address, regen loads rdata
//   mem_address, lba, sector_cnt, dma_type, dma_req   per-channel command outputs
//   dma_ack, dma_done, dma_err  per-channel engine handshake inputs
//   irq                         registered interrupt
// Optional feature macro DMA_REGS_IRQ_EN: adds IRQ_MASK / IRQ_PEND words after the last
// channel window; when undefined irq is tied low and those words read the default pattern.
module dma_chan_regs
  import dma_regs_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter logic [7:0]  CHAN_BASE = 8'hc0,
  parameter int unsigned DMA_ALIGN = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [31:0]               bram_waddr,
  input  logic [31:0]               bram_wdata,
  input  logic [3:0]                bram_wstb,
  input  logic                      bram_wen,
  input  logic [31:0]               bram_raddr,
  input  logic                      bram_ren,
  input  logic                      bram_regen,
  output logic [31:0]               bram_rdata,
  output logic [CHANNELS*32-1:0]    mem_address,
  output logic [CHANNELS*48-1:0]    lba,
  output logic [CHANNELS*CNT_W-1:0] sector_cnt,
  output logic [CHANNELS-1:0]       dma_type,
  output logic [CHANNELS-1:0]       dma_req,
  input  logic [CHANNELS-1:0]       dma_ack,
  input  logic [CHANNELS-1:0]       dma_done,
  input  logic [CHANNELS-1:0]       dma_err,
  output logic                      irq
);

  // 9-bit address arithmetic so windows ending at 0x100 still decode
  localparam logic [8:0] ChanLo   = {1'b0, CHAN_BASE};
  localparam logic [8:0] ChanSpan = 9'(8 * CHANNELS);
  localparam logic [8:0] IrqBase  = 9'(32'(CHAN_BASE) + 8 * CHANNELS);
  localparam logic [8:0] IrqPend  = 9'(32'(IrqBase) + 1);

  logic [31:0]         wmask;
  logic [8:0]          w_rel, r_rel;
  logic                w_hit, r_hit;
  logic [CHANNELS-1:0] chan_wr_en;
  logic [CHANNELS-1:0] done_evt;
  logic [31:0]         chan_rdata [CHANNELS];
  logic [7:0]          raddr_q;
  logic [31:0]         rdata_q, rdata_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{bram_waddr[31:8], bram_raddr[31:8]};

  assign wmask = strb_to_mask(bram_wstb);

  always_comb begin
    w_rel = {1'b0, bram_waddr[7:0]} - ChanLo;
    w_hit = ({1'b0, bram_waddr[7:0]} >= ChanLo) && (w_rel < ChanSpan);
    r_rel = {1'b0, raddr_q} - ChanLo;
    r_hit = ({1'b0, raddr_q} >= ChanLo) && (r_rel < ChanSpan);
    chan_wr_en = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chan_wr_en[c] = bram_wen && w_hit && (w_rel[5:3] == 3'(c));
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    dma_chan_ctrl #(
      .DMA_ALIGN(DMA_ALIGN),
      .CNT_W    (CNT_W)
    ) u_chan (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .wr_en      (chan_wr_en[c]),
      .wr_off     (w_rel[2:0]),
      .wr_data    (bram_wdata),
      .wr_mask    (wmask),
      .rd_off     (r_rel[2:0]),
      .rd_data    (chan_rdata[c]),
      .mem_address(mem_address[c*32 +: 32]),
      .lba        (lba[c*48 +: 48]),
      .sector_cnt (sector_cnt[c*CNT_W +: CNT_W]),
      .dma_type   (dma_type[c]),
      .dma_req    (dma_req[c]),
      .dma_ack    (dma_ack[c]),
      .dma_done   (dma_done[c]),
      .dma_err    (dma_err[c]),
      .done_evt   (done_evt[c])
    );
  end

`ifdef DMA_REGS_IRQ_EN
  logic [CHANNELS-1:0] irq_mask_q, irq_pend_q, pend_w1c;
  logic                irq_q, mask_wr, pend_wr;

  assign mask_wr  = bram_wen && ({1'b0, bram_waddr[7:0]} == IrqBase);
  assign pend_wr  = bram_wen && ({1'b0, bram_waddr[7:0]} == IrqPend);
  assign pend_w1c = pend_wr ? CHANNELS'(bram_wdata & wmask) : '0;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      irq_mask_q <= '0;
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (mask_wr) begin
        irq_mask_q <= CHANNELS'(byte_merge(32'(irq_mask_q), bram_wdata, wmask));
      end
      // New completions override a same-cycle clear
      irq_pend_q <= (irq_pend_q & ~pend_w1c) | done_evt;
      irq_q      <= |(irq_pend_q & irq_mask_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_done_evt;
  assign unused_done_evt = |done_evt;
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_d = DefaultRdata;
    if (r_hit) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (r_rel[5:3] == 3'(c)) rdata_d = chan_rdata[c];
      end
    end
`ifdef DMA_REGS_IRQ_EN
    if ({1'b0, raddr_q} == IrqBase) rdata_d = 32'(irq_mask_q);
    if ({1'b0, raddr_q} == IrqPend) rdata_d = 32'(irq_pend_q);
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      if (bram_ren) raddr_q <= bram_raddr[7:0];
      if (bram_regen) rdata_q <= rdata_d;
    end
  end

  assign bram_rdata = rdata_q;

endmodule

// File: tb/tb_dma_chan_regs.sv
// tb_dma_chan_regs: scoreboard bench for dma_chan_regs (default parameters).
module tb_dma_chan_regs;

  localparam int unsigned CH = 4;
  localparam logic [31:0] DEF = 32'hd34db33f;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [31:0]     bram_waddr = '0, bram_wdata = '0, bram_raddr = '0;
  logic [3:0]      bram_wstb = '0;
  logic            bram_wen = 1'b0, bram_ren = 1'b0, bram_regen = 1'b0;
  logic [31:0]     bram_rdata;
  logic [CH*32-1:0] mem_address;
  logic [CH*48-1:0] lba;
  logic [CH*16-1:0] sector_cnt;
  logic [CH-1:0]   dma_type, dma_req;
  logic [CH-1:0]   dma_ack = '0, dma_done = '0, dma_err = '0;
  logic            irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] sb[$];

  always #5 ACLK = ~ACLK;

  dma_chan_regs #(
    .CHANNELS (CH),
    .CHAN_BASE(8'hc0),
    .DMA_ALIGN(7),
    .CNT_W    (16)
  ) u_dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .bram_wstb  (bram_wstb),
    .bram_wen   (bram_wen),
    .bram_raddr (bram_raddr),
    .bram_ren   (bram_ren),
    .bram_regen (bram_regen),
    .bram_rdata (bram_rdata),
    .mem_address(mem_address),
    .lba        (lba),
    .sector_cnt (sector_cnt),
    .dma_type   (dma_type),
    .dma_req    (dma_req),
    .dma_ack    (dma_ack),
    .dma_done   (dma_done),
    .dma_err    (dma_err),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [7:0] ca(input int c, input int off);
    return 8'(32'hc0 + 8 * c + off);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bram_waddr = {24'h0, a};
    bram_wdata = d;
    bram_wstb  = s;
    bram_wen   = 1'b1;
    tick();
    bram_wen   = 1'b0;
    bram_wstb  = '0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] e;
    sb.push_back(exp);
    bram_raddr = {24'h0, a};
    bram_ren   = 1'b1;
    tick();
    bram_ren   = 1'b0;
    bram_regen = 1'b1;
    tick();
    bram_regen = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, 64'(bram_rdata), 64'(e));
    end
  endtask

  task automatic ack(input int c);
    dma_ack[c] = 1'b1;
    tick();
    dma_ack[c] = 1'b0;
  endtask

  task automatic done(input int c, input logic e);
    dma_done[c] = 1'b1;
    dma_err[c]  = e;
    tick();
    dma_done[c] = 1'b0;
    dma_err[c]  = 1'b0;
  endtask

  task automatic xfer(input int c);
    wr(ca(c, 5), 32'h1, 4'h1);
    ack(c);
    done(c, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    repeat (3) tick();
    chk("rst_rdata", 64'(bram_rdata), 64'h0);
    chk("rst_req", 64'(dma_req), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_mem", mem_address[63:0], 64'h0);
    ARESETN = 1'b1;
    tick();
    rd("rst_status0", ca(0, 6), 32'h0);

    // Byte-merged ADDR writes and alignment
    wr(ca(0, 0), 32'h12345fff, 4'b0011);
    chk("mem_align", 64'(mem_address[31:0]), 64'h00005f80);
    rd("addr_merge", ca(0, 0), 32'h00005fff);
    wr(ca(0, 0), 32'haabbccdd, 4'b1000);
    chk("mem_merge_hi", 64'(mem_address[31:0]), 64'haa005f80);
    rd("addr_merge_hi", ca(0, 0), 32'haa005fff);

    wr(ca(0, 1), 32'hdeadbeef, 4'hf);
    wr(ca(0, 2), 32'hffff1234, 4'hf);
    wr(ca(0, 3), 32'h00000010, 4'hf);
    wr(ca(0, 4), 32'h00000001, 4'h1);
    chk("lba0", 64'(lba[47:0]), 64'h1234deadbeef);
    chk("cnt0", 64'(sector_cnt[15:0]), 64'h10);
    chk("type0", 64'(dma_type[0]), 64'h1);
    rd("lba_hi", ca(0, 2), 32'h00001234);

    // Start / ack / done
    wr(ca(0, 5), 32'h1, 4'h1);
    chk("req_start", 64'(dma_req[0]), 64'h1);
    rd("stat_pend", ca(0, 6), 32'h1);
    rd("ctrl_reads0", ca(0, 5), 32'h0);
    ack(0);
    chk("req_acked", 64'(dma_req[0]), 64'h0);
    rd("stat_busy", ca(0, 6), 32'h2);
    done(0, 1'b0);
    rd("stat_done", ca(0, 6), 32'h00010004);
    rd("last_addr", ca(0, 7), 32'haa005fff);
    ack(0);
    rd("ack_in_idle", ca(0, 6), 32'h00010004);

    // Illegal commands while busy
    wr(ca(0, 5), 32'h1, 4'h1);
    ack(0);
    wr(ca(0, 5), 32'h1, 4'h1);
    rd("start_in_busy", ca(0, 6), 32'h00010016);
    wr(ca(0, 0), 32'h0, 4'hf);
    rd("addr_dropped", ca(0, 0), 32'haa005fff);
    wr(ca(0, 5), 32'h4, 4'h1);
    rd("clear_busy", ca(0, 6), 32'h00010002);
    done(0, 1'b0);
    rd("stat_done2", ca(0, 6), 32'h00020004);
    done(0, 1'b0);
    rd("done_in_idle", ca(0, 6), 32'h00020004);

    // Abort before ack
    wr(ca(0, 5), 32'h4, 4'h1);
    wr(ca(0, 5), 32'h1, 4'h1);
    chk("req_abort_pre", 64'(dma_req[0]), 64'h1);
    wr(ca(0, 5), 32'h2, 4'h1);
    chk("req_abort", 64'(dma_req[0]), 64'h0);
    rd("stat_abort", ca(0, 6), 32'h00020000);

    // Error completion together with a clear: set wins
    wr(ca(0, 5), 32'h1, 4'h1);
    ack(0);
    dma_done[0] = 1'b1;
    dma_err[0]  = 1'b1;
    wr(ca(0, 5), 32'h4, 4'h1);
    dma_done[0] = 1'b0;
    dma_err[0]  = 1'b0;
    rd("err_and_clr", ca(0, 6), 32'h0003000c);

    // Start and clear in one write; CTRL with no strobe does nothing
    wr(ca(0, 5), 32'h5, 4'h1);
    rd("start_clr", ca(0, 6), 32'h00030001);
    wr(ca(0, 5), 32'h2, 4'h1);
    wr(ca(0, 5), 32'h1, 4'h0);
    rd("ctrl_nostrb", ca(0, 6), 32'h00030000);

    // Interrupt path on channel 1
`ifdef DMA_REGS_IRQ_EN
    wr(8'he0, 32'h2, 4'hf);
    rd("irq_mask", 8'he0, 32'h2);
    wr(ca(1, 5), 32'h1, 4'h1);
    ack(1);
    done(1, 1'b0);
    chk("irq_lag", 64'(irq), 64'h0);
    tick();
    chk("irq_set", 64'(irq), 64'h1);
    rd("irq_pend", 8'he1, 32'h2);
    wr(8'he1, 32'h2, 4'hf);
    chk("irq_clr_lag", 64'(irq), 64'h1);
    tick();
    chk("irq_clr", 64'(irq), 64'h0);
    rd("irq_pend_clr", 8'he1, 32'h0);
`else
    wr(8'he0, 32'hff, 4'hf);
    xfer(1);
    tick();
    chk("irq_tied", 64'(irq), 64'h0);
    rd("irq_mask_unmapped", 8'he0, DEF);
    rd("irq_pend_unmapped", 8'he1, DEF);
`endif
    rd("stat_ch1", ca(1, 6), 32'h00010004);

    // Completion counter across the low-byte carry
    for (int i = 0; i < 300; i++) xfer(2);
    rd("cnt_300", ca(2, 6), 32'h012c0004);

    // Reset in the middle of a transfer
    wr(ca(3, 5), 32'h1, 4'h1);
    ack(3);
    rd("stat_busy3", ca(3, 6), 32'h2);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    chk("rst_busy_req", 64'(dma_req), 64'h0);
    chk("rst_busy_irq", 64'(irq), 64'h0);
    rd("rst_busy_stat3", ca(3, 6), 32'h0);
    rd("rst_stat0", ca(0, 6), 32'h0);
    rd("rst_addr0", ca(0, 0), 32'h0);

    // Unmapped read, then rdata holds without regen
    rd("unmapped_00", 8'h00, DEF);
    sb.push_back(DEF);
    bram_raddr = {24'h0, ca(0, 6)};
    bram_ren   = 1'b1;
    tick();
    bram_ren   = 1'b0;
    repeat (2) tick();
    e = sb.pop_front();
    chk("rdata_hold", 64'(bram_rdata), 64'(e));
    rd("unmapped_e2", 8'he2, DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
